lcd_msg_sequencer: RTL and testbench



---
 rtl/lcd_pkg.sv | 25 ++
 rtl/lcd_msg_rom.sv | 35 +++
 rtl/lcd_msg_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_lcd_msg_sequencer.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared definitions for the I2C character-LCD message sequencer:
// FSM state encoding, LCD command bytes, default bus address and index widths.
package lcd_pkg;

    // Sequencer FSM states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LAUNCH = 3'd1,
        ST_SEND   = 3'd2,
        ST_FINISH = 3'd3,
        ST_ABORT  = 3'd4
    } seq_state_t;

    // LCD command bytes: prefix followed by the command code
    localparam logic [7:0] LCD_CMD_PREFIX   = 8'hFE;
    localparam logic [7:0] LCD_CMD_CLEAR    = 8'h51;

    // Default I2C address byte of the display
    localparam logic [7:0] LCD_DEFAULT_ADDR = 8'h50;

    // Index widths: up to 8 messages, up to 31 payload bytes (+ address byte)
    localparam int MSG_IDX_W  = 3;
    localparam int BYTE_IDX_W = 5;

endpackage

// File: rtl/lcd_msg_rom.sv
// Combinational message store: maps (message, byte index) onto the byte to
// send, a last-byte flag and the payload length. Byte index 0 is the address
// byte; index j>0 is payload byte j-1.
module lcd_msg_rom
    import lcd_pkg::*;
#(
    parameter int                           NUM_MSG   = 4,
    parameter int                           MAX_LEN   = 16,
    parameter logic [7:0]                   I2C_ADDR  = LCD_DEFAULT_ADDR,
    parameter logic [NUM_MSG*MAX_LEN*8-1:0] MSG_BYTES = {(NUM_MSG*MAX_LEN){8'h20}},
    parameter logic [NUM_MSG*5-1:0]         MSG_LEN   = {NUM_MSG{5'd1}}
) (
    input  logic [MSG_IDX_W-1:0]  i_msg,
    input  logic [BYTE_IDX_W-1:0] i_byte_idx,
    output logic [7:0]            o_data,
    output logic                  o_last,
    output logic [BYTE_IDX_W-1:0] o_len
);

    // Select the current byte; out-of-range indices fall back to the address byte
    // NOTE: every output gets a default before any branch so no latch is inferred.
    always_comb begin
        o_data = I2C_ADDR;
        o_len  = 5'd1;
        o_last = 1'b0;
        if (int'(i_msg) < NUM_MSG) begin
            o_len  = MSG_LEN[int'(i_msg)*5 +: 5];
            o_last = (i_byte_idx == o_len);
            if (i_byte_idx != '0 && int'(i_byte_idx) <= MAX_LEN) begin
                o_data = MSG_BYTES[(int'(i_msg)*MAX_LEN + int'(i_byte_idx) - 1)*8 +: 8];
            end
        end
    end

endmodule

// File: rtl/lcd_msg_sequencer.sv
// Message sequencer for the I2C character LCD. Queues per-message requests,
// picks the lowest pending index, and streams address + payload bytes to the
// byte-level I2C controller, advancing on each ack edge and aborting when a
// byte is not acknowledged within ACK_TIMEOUT cycles. Outputs are registered
// from the FSM state, so they appear one cycle after the state that drives them.
module lcd_msg_sequencer
    import lcd_pkg::*;
#(
    parameter int                           NUM_MSG     = 4,
    parameter int                           MAX_LEN     = 16,
    parameter logic [7:0]                   I2C_ADDR    = LCD_DEFAULT_ADDR,
    parameter logic [NUM_MSG*MAX_LEN*8-1:0] MSG_BYTES   = {(NUM_MSG*MAX_LEN){8'h20}},
    parameter logic [NUM_MSG*5-1:0]         MSG_LEN     = {NUM_MSG{5'd1}},
    parameter int                           ACK_TIMEOUT = 2000
) (
    input  logic                 clk_50K,
    input  logic                 rstn,
    input  logic [NUM_MSG-1:0]   req,
    output logic                 i2c_start,
    output logic [7:0]           i2c_data,
    output logic                 i2c_last,
    input  logic                 i2c_ack,
    output logic                 busy,
    output logic [2:0]           cur_msg,
    output logic [NUM_MSG-1:0]   pending,
    output logic                 done,
    output logic                 err
);

    localparam int CNT_W = $clog2(ACK_TIMEOUT);

    seq_state_t              r_state;
    seq_state_t              w_next_state;

    logic [NUM_MSG-1:0]      r_sync1;
    logic [NUM_MSG-1:0]      r_sync2;
    logic [NUM_MSG-1:0]      r_req_prev;
    logic [NUM_MSG-1:0]      w_req_rise;
    logic                    r_ack_prev;
    logic                    w_ack_rise;

    logic [NUM_MSG-1:0]      r_pending;
    logic [MSG_IDX_W-1:0]    r_cur_msg;
    logic [BYTE_IDX_W-1:0]   r_byte_idx;
    logic [CNT_W-1:0]        r_cnt;
    logic                    w_timeout;

    logic                    w_sel_valid;
    logic [MSG_IDX_W-1:0]    w_sel_idx;
    logic                    w_launch;
    logic [NUM_MSG-1:0]      w_clr_mask;

    logic [7:0]              w_rom_data;
    logic                    w_rom_last;
    logic [BYTE_IDX_W-1:0]   w_rom_len;

    logic                    r_start;
    logic                    r_busy;
    logic                    r_done;
    logic                    r_err;
    logic [7:0]              r_data;
    logic                    r_last;

    lcd_msg_rom #(
        .NUM_MSG   (NUM_MSG),
        .MAX_LEN   (MAX_LEN),
        .I2C_ADDR  (I2C_ADDR),
        .MSG_BYTES (MSG_BYTES),
        .MSG_LEN   (MSG_LEN)
    ) u_rom (
        .i_msg      (r_cur_msg),
        .i_byte_idx (r_byte_idx),
        .o_data     (w_rom_data),
        .o_last     (w_rom_last),
        .o_len      (w_rom_len)
    );

    assign w_req_rise = r_sync2 & ~r_req_prev;
    assign w_ack_rise = i2c_ack & ~r_ack_prev;
    assign w_timeout  = (r_cnt == CNT_W'(ACK_TIMEOUT - 1));
    assign w_launch   = (r_state == ST_IDLE) && w_sel_valid;
    assign w_clr_mask = w_launch ? (NUM_MSG'(1) << w_sel_idx) : '0;

    // Request synchroniser, request/ack edge-detect history
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_50K or negedge rstn) begin
        if (!rstn) begin
            r_sync1    <= '0;
            r_sync2    <= '0;
            r_req_prev <= '0;
            r_ack_prev <= 1'b0;
        end else begin
            r_sync1    <= req;
            r_sync2    <= r_sync1;
            r_req_prev <= r_sync2;
            r_ack_prev <= i2c_ack;
        end
    end

    // Lowest pending index wins arbitration
    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_idx   = '0;
        for (int m = NUM_MSG - 1; m >= 0; m--) begin
            if (r_pending[m]) begin
                w_sel_valid = 1'b1;
                w_sel_idx   = MSG_IDX_W'(m);
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk_50K or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state: an ack edge takes priority over the timeout
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:   if (w_sel_valid) w_next_state = ST_LAUNCH;
            ST_LAUNCH: w_next_state = ST_SEND;
            ST_SEND: begin
                if (w_ack_rise) begin
                    if (w_rom_last) w_next_state = ST_FINISH;
                end else if (w_timeout) begin
                    w_next_state = ST_ABORT;
                end
            end
            ST_FINISH: w_next_state = ST_IDLE;
            ST_ABORT:  w_next_state = ST_IDLE;
            default:   w_next_state = ST_IDLE;
        endcase
    end

    // Request queue, message/byte pointers and per-byte timeout counter;
    // a new request edge beats the launch clear of the same index
    always_ff @(posedge clk_50K or negedge rstn) begin
        if (!rstn) begin
            r_pending  <= '0;
            r_cur_msg  <= '0;
            r_byte_idx <= '0;
            r_cnt      <= '0;
        end else begin
            r_pending <= (r_pending & ~w_clr_mask) | w_req_rise;
            if (w_launch) begin
                r_cur_msg  <= w_sel_idx;
                r_byte_idx <= '0;
            end
            case (r_state)
                ST_LAUNCH: r_cnt <= '0;
                ST_SEND: begin
                    if (w_ack_rise) begin
                        if (!w_rom_last && r_byte_idx < w_rom_len) begin
                            r_byte_idx <= r_byte_idx + 5'd1;
                            r_cnt      <= '0;
                        end
                    end else if (!w_timeout) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Registered outputs derived from the current state and ROM selection
    always_ff @(posedge clk_50K or negedge rstn) begin
        if (!rstn) begin
            r_start <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_data  <= I2C_ADDR;
            r_last  <= 1'b0;
        end else begin
            r_start <= (r_state == ST_LAUNCH);
            r_busy  <= (r_state != ST_IDLE);
            r_done  <= (r_state == ST_FINISH);
            r_err   <= (r_state == ST_ABORT);
            r_data  <= w_rom_data;
            r_last  <= (r_state == ST_SEND) && w_rom_last;
        end
    end

    assign i2c_start = r_start;
    assign i2c_data  = r_data;
    assign i2c_last  = r_last;
    assign busy      = r_busy;
    assign cur_msg   = r_cur_msg;
    assign pending   = r_pending;
    assign done      = r_done;
    assign err       = r_err;

endmodule

// File: tb/tb_lcd_msg_sequencer.sv
// Scoreboard bench for lcd_msg_sequencer: stimulus pushes expected events
// (start, acknowledged bytes, done, err) into a queue, a monitor pops and
// compares them as the DUT presents them, and a responder plays the I2C
// controller by acknowledging bytes.
module tb_lcd_msg_sequencer;

    typedef enum int {EV_START, EV_BYTE, EV_DONE, EV_ERR} ev_kind_t;
    typedef enum int {ACK_NORMAL, ACK_SILENT, ACK_HELD} ack_mode_t;

    typedef struct {
        ev_kind_t   kind;
        logic [7:0] data;
        logic       last;
        logic [2:0] msg;
    } ev_t;

    localparam logic [127:0] M0 = {{14{8'h20}}, 8'h51, 8'hFE};
    localparam logic [127:0] M1 = {{3{8'h20}}, 8'h21, 8'h64, 8'h6C, 8'h72, 8'h6F, 8'h77,
                                   8'h20, 8'h2C, 8'h6F, 8'h6C, 8'h6C, 8'h65, 8'h48};
    localparam logic [127:0] M2 = {{14{8'h20}}, 8'h42, 8'h41};
    localparam logic [127:0] M3 = {{14{8'h20}}, 8'h69, 8'h48};
    localparam logic [511:0] P_BYTES = {M3, M2, M1, M0};
    localparam logic [19:0]  P_LEN   = {5'd2, 5'd2, 5'd13, 5'd2};

    logic       clk_50K = 1'b0;
    logic       rstn;
    logic [3:0] req;
    logic       i2c_start;
    logic [7:0] i2c_data;
    logic       i2c_last;
    logic       i2c_ack;
    logic       busy;
    logic [2:0] cur_msg;
    logic [3:0] pending;
    logic       done;
    logic       err;

    ev_t        exp_q[$];
    ack_mode_t  ack_mode = ACK_NORMAL;
    int         acks_given = 0;
    int         n_checks = 0;
    int         n_errors = 0;
    logic       mon_ack_prev = 1'b0;

    logic [7:0] hello [13] = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h2C, 8'h20,
                               8'h77, 8'h6F, 8'h72, 8'h6C, 8'h64, 8'h21};

    lcd_msg_sequencer #(
        .NUM_MSG     (4),
        .MAX_LEN     (16),
        .I2C_ADDR    (8'h50),
        .MSG_BYTES   (P_BYTES),
        .MSG_LEN     (P_LEN),
        .ACK_TIMEOUT (8)
    ) dut (
        .clk_50K   (clk_50K),
        .rstn      (rstn),
        .req       (req),
        .i2c_start (i2c_start),
        .i2c_data  (i2c_data),
        .i2c_last  (i2c_last),
        .i2c_ack   (i2c_ack),
        .busy      (busy),
        .cur_msg   (cur_msg),
        .pending   (pending),
        .done      (done),
        .err       (err)
    );

    always #10 clk_50K = ~clk_50K;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] msg_byte(input int m, input int j);
        case (m)
            0:       return (j == 0) ? 8'hFE : 8'h51;
            1:       return hello[j];
            2:       return (j == 0) ? 8'h41 : 8'h42;
            default: return (j == 0) ? 8'h48 : 8'h69;
        endcase
    endfunction

    function automatic int msg_len(input int m);
        return (m == 1) ? 13 : 2;
    endfunction

    function automatic ev_t mk(input ev_kind_t k, input logic [7:0] d, input logic l, input int m);
        ev_t e;
        e.kind = k;
        e.data = d;
        e.last = l;
        e.msg  = 3'(m);
        return e;
    endfunction

    // Expected events for message m; only the first n_payload payload bytes
    // and no done when the transfer is cut short
    task automatic push_msg(input int m, input int n_payload, input bit complete);
        exp_q.push_back(mk(EV_START, 8'h00, 1'b0, m));
        exp_q.push_back(mk(EV_BYTE, 8'h50, 1'b0, m));
        for (int j = 0; j < n_payload; j++)
            exp_q.push_back(mk(EV_BYTE, msg_byte(m, j), (j == msg_len(m) - 1), m));
        if (complete) exp_q.push_back(mk(EV_DONE, 8'h00, 1'b0, m));
    endtask

    task automatic take(input ev_kind_t k, input logic [7:0] d, input logic l, input logic [2:0] m);
        ev_t e;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_event: got kind=%0d data=%02h msg=%0d, expected none", k, d, m);
        end else begin
            e = exp_q.pop_front();
            check("event_kind", k, e.kind);
            if (e.kind == k) begin
                if (k == EV_BYTE) begin
                    check("byte_data", d, e.data);
                    check("byte_last", l, e.last);
                end else begin
                    check("event_msg", m, e.msg);
                end
            end
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_start"},   i2c_start, 0);
        check({tag, "_busy"},    busy,      0);
        check({tag, "_done"},    done,      0);
        check({tag, "_err"},     err,       0);
        check({tag, "_pending"}, pending,   0);
        check({tag, "_cur_msg"}, cur_msg,   0);
        check({tag, "_last"},    i2c_last,  0);
        check({tag, "_data"},    i2c_data,  8'h50);
    endtask

    task automatic wait_start(input int budget);
        int n = 0;
        do begin
            @(negedge clk_50K);
            n++;
        end while (!i2c_start && n < budget);
        check("start_seen", i2c_start, 1);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || busy || pending != 0) && n < budget) begin
            @(negedge clk_50K);
            n++;
        end
        check("drained_in_budget", (n < budget), 1);
    endtask

    // Monitor: pops one expected event per observed DUT event
    initial begin : monitor
        forever begin
            @(negedge clk_50K);
            if (rstn) begin
                if (i2c_start) take(EV_START, 8'h00, 1'b0, cur_msg);
                if (busy && i2c_ack && !mon_ack_prev) take(EV_BYTE, i2c_data, i2c_last, 3'd0);
                if (done) take(EV_DONE, 8'h00, 1'b0, cur_msg);
                if (err)  take(EV_ERR, 8'h00, 1'b0, cur_msg);
            end
            mon_ack_prev = i2c_ack;
        end
    end

    // Responder: acknowledges each byte three cycles after it is presented
    initial begin : responder
        i2c_ack = 1'b0;
        forever begin
            @(negedge clk_50K);
            if (rstn && i2c_start && ack_mode == ACK_NORMAL) begin
                logic fin;
                fin = 1'b0;
                while (!fin) begin
                    repeat (3) @(posedge clk_50K);
                    #1;
                    if (!rstn || !busy) break;
                    fin = i2c_last;
                    i2c_ack = 1'b1;
                    acks_given++;
                    @(posedge clk_50K);
                    #1;
                    i2c_ack = 1'b0;
                end
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin : stimulus
        int seen;
        int n;
        bit advanced;
        rstn = 1'b0;
        req  = '0;
        repeat (3) @(posedge clk_50K);
        #1;
        check_reset_vals("por");
        rstn = 1'b1;
        repeat (2) @(posedge clk_50K);
        #1;

        // Single message with request latency
        push_msg(0, 2, 1'b1);
        req[0] = 1'b1;
        seen = -1;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk_50K);
            @(negedge clk_50K);
            if (c == 2) check("pending_before_set", pending, 4'b0000);
            if (c == 3) check("pending_set_k2", pending, 4'b0001);
            if (c == 4) check("pending_cleared_k3", pending, 4'b0000);
            if (i2c_start && seen < 0) seen = c;
        end
        check("start_latency", seen, 5);
        req = '0;
        wait_idle(100);
        check("single_busy_low", busy, 0);
        check("single_done_low", done, 0);

        // Queue and priority: 3 then 1 arrive while 0 is in flight
        push_msg(0, 2, 1'b1);
        push_msg(1, 13, 1'b1);
        push_msg(3, 2, 1'b1);
        @(posedge clk_50K);
        #1;
        req[0] = 1'b1;
        wait_start(20);
        req[3] = 1'b1;
        repeat (2) @(negedge clk_50K);
        req[1] = 1'b1;
        repeat (4) @(negedge clk_50K);
        check("queued_pending", pending, 4'b1010);
        check("queued_cur_msg", cur_msg, 0);
        req = '0;
        wait_idle(400);

        // Re-request while in flight
        push_msg(2, 2, 1'b1);
        push_msg(2, 2, 1'b1);
        @(posedge clk_50K);
        #1;
        req[2] = 1'b1;
        wait_start(20);
        req[2] = 1'b0;
        repeat (3) @(negedge clk_50K);
        req[2] = 1'b1;
        repeat (4) @(negedge clk_50K);
        check("rerequest_pending", pending, 4'b0100);
        req = '0;
        wait_idle(200);

        // Timeout: no ack at all
        ack_mode = ACK_SILENT;
        exp_q.push_back(mk(EV_START, 8'h00, 1'b0, 3));
        exp_q.push_back(mk(EV_ERR, 8'h00, 1'b0, 3));
        @(posedge clk_50K);
        #1;
        req[3] = 1'b1;
        wait_start(20);
        n = 0;
        while (!err && n < 20) begin
            @(negedge clk_50K);
            n++;
        end
        check("err_after_start", n, 9);
        check("timeout_pending", pending, 4'b0000);
        @(negedge clk_50K);
        check("timeout_busy_low", busy, 0);
        req = '0;
        wait_idle(50);

        // Held ack: high across launch, never an edge
        ack_mode = ACK_HELD;
        i2c_ack  = 1'b1;
        exp_q.push_back(mk(EV_START, 8'h00, 1'b0, 0));
        exp_q.push_back(mk(EV_ERR, 8'h00, 1'b0, 0));
        repeat (2) @(posedge clk_50K);
        #1;
        req[0] = 1'b1;
        wait_start(20);
        advanced = 1'b0;
        n = 0;
        while (!err && n < 20) begin
            if (i2c_data != 8'h50) advanced = 1'b1;
            @(negedge clk_50K);
            n++;
        end
        check("held_no_advance", advanced, 0);
        check("held_err_after_start", n, 9);
        req = '0;
        wait_idle(50);
        i2c_ack  = 1'b0;
        ack_mode = ACK_NORMAL;
        repeat (2) @(posedge clk_50K);
        #1;

        // Asynchronous reset during byte 5 of message 1
        push_msg(1, 4, 1'b0);
        acks_given = 0;
        req[1] = 1'b1;
        wait_start(20);
        req[1] = 1'b0;
        req[3] = 1'b1;
        n = 0;
        while (acks_given < 5 && n < 100) begin
            @(negedge clk_50K);
            n++;
        end
        check("five_acks_seen", acks_given, 5);
        req[3] = 1'b0;
        check("pre_reset_pending", pending, 4'b1000);
        repeat (2) @(posedge clk_50K);
        #2;
        check("byte5_data", i2c_data, 8'h6F);
        rstn = 1'b0;
        #1;
        check_reset_vals("midreset");
        check("midreset_queue_empty", exp_q.size(), 0);
        repeat (4) @(posedge clk_50K);
        #3;
        rstn = 1'b1;
        repeat (2) @(posedge clk_50K);
        #1;
        check_reset_vals("post_release");

        // Request after release behaves like the first transfer
        push_msg(0, 2, 1'b1);
        req[0] = 1'b1;
        wait_start(20);
        req = '0;
        wait_idle(100);
        check("final_busy_low", busy, 0);
        check("final_queue_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
